// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-requester memory arbiter: request modes,
// FSM state encoding, the default response timeout and the request record.
package mem_arbiter_pkg;

  localparam logic MEMREQ_READ  = 1'b0;
  localparam logic MEMREQ_WRITE = 1'b1;

  localparam int TIMEOUT_CYCLES_DEFAULT = 1024;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_WAIT_RESP,
    ARB_RESPOND
  } arb_state_t;

  typedef struct packed {
    logic        mode;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } mem_req_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle of the memory arbiter: two requester ports and the memory port.
// The slave modport is the arbiter's view; master is the environment's view.
interface mem_arbiter_if;

  logic        m0_request_enable;
  logic        m0_req_mode;
  logic [31:0] m0_req_addr;
  logic [31:0] m0_req_wdata;
  logic [3:0]  m0_req_wstrb;
  logic        m0_response_enable;
  logic [31:0] m0_resp_data;
  logic        m0_resp_error;

  logic        m1_request_enable;
  logic        m1_req_mode;
  logic [31:0] m1_req_addr;
  logic [31:0] m1_req_wdata;
  logic [3:0]  m1_req_wstrb;
  logic        m1_response_enable;
  logic [31:0] m1_resp_data;
  logic        m1_resp_error;

  logic        request_enable;
  logic        req_mode;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        response_enable;
  logic [31:0] resp_data;
  logic        grant_id;

  modport slave (
    input  m0_request_enable, m0_req_mode, m0_req_addr, m0_req_wdata, m0_req_wstrb,
    output m0_response_enable, m0_resp_data, m0_resp_error,
    input  m1_request_enable, m1_req_mode, m1_req_addr, m1_req_wdata, m1_req_wstrb,
    output m1_response_enable, m1_resp_data, m1_resp_error,
    output request_enable, req_mode, req_addr, req_wdata, req_wstrb, grant_id,
    input  response_enable, resp_data
  );

  modport master (
    output m0_request_enable, m0_req_mode, m0_req_addr, m0_req_wdata, m0_req_wstrb,
    input  m0_response_enable, m0_resp_data, m0_resp_error,
    output m1_request_enable, m1_req_mode, m1_req_addr, m1_req_wdata, m1_req_wstrb,
    input  m1_response_enable, m1_resp_data, m1_resp_error,
    input  request_enable, req_mode, req_addr, req_wdata, req_wstrb, grant_id,
    output response_enable, resp_data
  );

endinterface

// File: rtl/arb_req_slot.sv
// Per-requester pending slot: latches a request pulse unless one is already
// pending; the arbiter clears it once the requester has been answered.
module arb_req_slot
  import mem_arbiter_pkg::*;
(
  input  logic     clk,
  input  logic     rstn,
  input  logic     req_en_i,
  input  mem_req_t req_i,
  input  logic     clr_i,
  output logic     pend_o,
  output mem_req_t slot_o
);

  logic     pend_q;
  mem_req_t slot_q;
  logic     capture;

  assign capture = req_en_i && !pend_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend_q <= 1'b0;
    end else if (capture) begin
      pend_q <= 1'b1;
    end else if (clr_i) begin
      pend_q <= 1'b0;
    end
  end

  // Payload is only meaningful while pending, so it carries no reset.
  always_ff @(posedge clk) begin
    if (capture) begin
      slot_q <= req_i;
    end
  end

  assign pend_o = pend_q;
  assign slot_o = slot_q;

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter with one outstanding transaction and timeout.
// Define MEM_ARBITER_ROUND_ROBIN_EN for round-robin; default is m0 priority.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input logic           clk,
  input logic           rstn,
  mem_arbiter_if.slave  bus
);

  logic       pend0, pend1;
  mem_req_t   slot0, slot1;
  mem_req_t   m0_in, m1_in;
  logic       clr0, clr1;
  logic       win_id;
  logic       timeout_hit;
  logic       finish;

  arb_state_t  state_q;
  logic [31:0] cnt_q;
  logic        last_grant_q;
  logic        grant_q;
  logic        request_enable_q;
  mem_req_t    req_q;
  logic        m0_rsp_en_q, m1_rsp_en_q;
  logic [31:0] m0_rdata_q, m1_rdata_q;
  logic        m0_err_q, m1_err_q;

  assign m0_in = {bus.m0_req_mode, bus.m0_req_addr, bus.m0_req_wdata, bus.m0_req_wstrb};
  assign m1_in = {bus.m1_req_mode, bus.m1_req_addr, bus.m1_req_wdata, bus.m1_req_wstrb};

  arb_req_slot u_slot0 (
    .clk(clk), .rstn(rstn), .req_en_i(bus.m0_request_enable), .req_i(m0_in),
    .clr_i(clr0), .pend_o(pend0), .slot_o(slot0)
  );

  arb_req_slot u_slot1 (
    .clk(clk), .rstn(rstn), .req_en_i(bus.m1_request_enable), .req_i(m1_in),
    .clr_i(clr1), .pend_o(pend1), .slot_o(slot1)
  );

  // Counter runs 0..TIMEOUT_CYCLES-1, so the error fires after exactly
  // TIMEOUT_CYCLES cycles spent in WAIT_RESP.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == 32'(TIMEOUT_CYCLES - 1));
  assign finish      = (state_q == ARB_WAIT_RESP) && (bus.response_enable || timeout_hit);
  assign clr0        = finish && !grant_q;
  assign clr1        = finish &&  grant_q;

  always_comb begin
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    win_id = (pend0 && pend1) ? ~last_grant_q : ~pend0;
`else
    win_id = ~pend0;
`endif
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q          <= ARB_IDLE;
      cnt_q            <= '0;
      last_grant_q     <= 1'b1;
      grant_q          <= 1'b0;
      request_enable_q <= 1'b0;
      req_q            <= '0;
      m0_rsp_en_q      <= 1'b0;
      m1_rsp_en_q      <= 1'b0;
      m0_rdata_q       <= '0;
      m1_rdata_q       <= '0;
      m0_err_q         <= 1'b0;
      m1_err_q         <= 1'b0;
    end else begin
      request_enable_q <= 1'b0;
      m0_rsp_en_q      <= 1'b0;
      m1_rsp_en_q      <= 1'b0;
      case (state_q)
        ARB_IDLE: begin
          if (pend0 || pend1) begin
            grant_q          <= win_id;
            req_q            <= win_id ? slot1 : slot0;
            request_enable_q <= 1'b1;
            cnt_q            <= '0;
            state_q          <= ARB_WAIT_RESP;
          end
        end
        ARB_WAIT_RESP: begin
          if (finish) begin
            if (grant_q) begin
              m1_rsp_en_q <= 1'b1;
              m1_rdata_q  <= bus.response_enable ? bus.resp_data : 32'h0;
              m1_err_q    <= !bus.response_enable;
            end else begin
              m0_rsp_en_q <= 1'b1;
              m0_rdata_q  <= bus.response_enable ? bus.resp_data : 32'h0;
              m0_err_q    <= !bus.response_enable;
            end
            last_grant_q <= grant_q;
            state_q      <= ARB_RESPOND;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        ARB_RESPOND: state_q <= ARB_IDLE;
        default:     state_q <= ARB_IDLE;
      endcase
    end
  end

  assign bus.request_enable     = request_enable_q;
  assign bus.req_mode           = req_q.mode;
  assign bus.req_addr           = req_q.addr;
  assign bus.req_wdata          = req_q.wdata;
  assign bus.req_wstrb          = req_q.wstrb;
  assign bus.grant_id           = grant_q;
  assign bus.m0_response_enable = m0_rsp_en_q;
  assign bus.m0_resp_data       = m0_rdata_q;
  assign bus.m0_resp_error      = m0_err_q;
  assign bus.m1_response_enable = m1_rsp_en_q;
  assign bus.m1_resp_data       = m1_rdata_q;
  assign bus.m1_resp_error      = m1_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed stimulus pushes expected memory
// requests and responses; a negedge monitor pops and compares them.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct {
    logic        gid;
    logic        mode;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } exp_req_t;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_rsp_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  exp_req_t exp_req[$];
  exp_rsp_t exp_rsp0[$];
  exp_rsp_t exp_rsp1[$];

  mem_arbiter_if bus();

  mem_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk),
    .rstn(rstn),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic expect_req(input logic gid, input logic mode, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] wstrb);
    exp_req.push_back('{gid, mode, addr, wdata, wstrb});
  endtask

  task automatic expect_rsp(input logic id, input logic [31:0] data, input logic err);
    if (id) exp_rsp1.push_back('{data, err});
    else    exp_rsp0.push_back('{data, err});
  endtask

  // Scoreboard monitor: every visible pulse must match the head of its queue.
  always @(negedge clk) begin : monitor
    exp_req_t er;
    exp_rsp_t es;
    if (bus.request_enable) begin
      checks++;
      if (exp_req.size() == 0) begin
        errors++;
        $display("FAIL unexpected_req gid=%0d addr=%h", bus.grant_id, bus.req_addr);
      end else begin
        er = exp_req.pop_front();
        if (bus.grant_id !== er.gid || bus.req_mode !== er.mode || bus.req_addr !== er.addr ||
            bus.req_wdata !== er.wdata || bus.req_wstrb !== er.wstrb) begin
          errors++;
          $display("FAIL req got gid=%0d mode=%0d addr=%h wdata=%h wstrb=%h exp gid=%0d mode=%0d addr=%h wdata=%h wstrb=%h",
                   bus.grant_id, bus.req_mode, bus.req_addr, bus.req_wdata, bus.req_wstrb,
                   er.gid, er.mode, er.addr, er.wdata, er.wstrb);
        end
      end
    end
    if (bus.m0_response_enable) begin
      checks++;
      if (exp_rsp0.size() == 0) begin
        errors++;
        $display("FAIL unexpected_m0_rsp data=%h err=%0d", bus.m0_resp_data, bus.m0_resp_error);
      end else begin
        es = exp_rsp0.pop_front();
        if (bus.m0_resp_data !== es.data || bus.m0_resp_error !== es.err) begin
          errors++;
          $display("FAIL m0_rsp got data=%h err=%0d exp data=%h err=%0d",
                   bus.m0_resp_data, bus.m0_resp_error, es.data, es.err);
        end
      end
    end
    if (bus.m1_response_enable) begin
      checks++;
      if (exp_rsp1.size() == 0) begin
        errors++;
        $display("FAIL unexpected_m1_rsp data=%h err=%0d", bus.m1_resp_data, bus.m1_resp_error);
      end else begin
        es = exp_rsp1.pop_front();
        if (bus.m1_resp_data !== es.data || bus.m1_resp_error !== es.err) begin
          errors++;
          $display("FAIL m1_rsp got data=%h err=%0d exp data=%h err=%0d",
                   bus.m1_resp_data, bus.m1_resp_error, es.data, es.err);
        end
      end
    end
  end

  task automatic drive(input logic id, input logic mode, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] wstrb);
    if (id) begin
      bus.m1_request_enable = 1'b1; bus.m1_req_mode = mode; bus.m1_req_addr = addr;
      bus.m1_req_wdata = wdata; bus.m1_req_wstrb = wstrb;
    end else begin
      bus.m0_request_enable = 1'b1; bus.m0_req_mode = mode; bus.m0_req_addr = addr;
      bus.m0_req_wdata = wdata; bus.m0_req_wstrb = wstrb;
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
    bus.m0_request_enable = 1'b0;
    bus.m1_request_enable = 1'b0;
    bus.response_enable   = 1'b0;
  endtask

  task automatic pulse(input logic id, input logic mode, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] wstrb);
    drive(id, mode, addr, wdata, wstrb);
    tick();
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (bus.request_enable) begin
        ok = 1'b1;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL wait_req got=none exp=request_enable");
  endtask

  task automatic respond_now(input int delay, input logic [31:0] d);
    repeat (delay) @(posedge clk);
    #1;
    bus.response_enable = 1'b1;
    bus.resp_data       = d;
    tick();
  endtask

  task automatic mem_respond(input int delay, input logic [31:0] d);
    bit ok;
    wait_req(ok);
    if (ok) respond_now(delay, d);
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      if (exp_req.size() == 0 && exp_rsp0.size() == 0 && exp_rsp1.size() == 0) begin
        repeat (2) @(posedge clk);
        #1;
        return;
      end
      @(posedge clk);
    end
    checks++;
    errors++;
    $display("FAIL drain got=%0d/%0d/%0d exp=0/0/0 pending expectations",
             exp_req.size(), exp_rsp0.size(), exp_rsp1.size());
    #1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_request_enable"}, 32'(bus.request_enable), 32'h0);
    check({tag, "_grant_id"},       32'(bus.grant_id), 32'h0);
    check({tag, "_req_fields"},     32'(bus.req_mode) | bus.req_addr | bus.req_wdata | 32'(bus.req_wstrb), 32'h0);
    check({tag, "_m0_rsp_en"},      32'(bus.m0_response_enable), 32'h0);
    check({tag, "_m1_rsp_en"},      32'(bus.m1_response_enable), 32'h0);
    check({tag, "_m0_data"},        bus.m0_resp_data, 32'h0);
    check({tag, "_m1_data"},        bus.m1_resp_data, 32'h0);
    check({tag, "_errors"},         32'({bus.m0_resp_error, bus.m1_resp_error}), 32'h0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  initial begin
    bit ok;
    int n;
    logic [31:0] d0, d1;
    bus.m0_request_enable = 1'b0; bus.m0_req_mode = 1'b0; bus.m0_req_addr = '0;
    bus.m0_req_wdata = '0; bus.m0_req_wstrb = '0;
    bus.m1_request_enable = 1'b0; bus.m1_req_mode = 1'b0; bus.m1_req_addr = '0;
    bus.m1_req_wdata = '0; bus.m1_req_wstrb = '0;
    bus.response_enable = 1'b0; bus.resp_data = '0;

    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk); #1;
    rstn = 1'b1;

    // Single m0 read, answered three cycles after the request
    @(posedge clk); #1;
    expect_req(1'b0, MEMREQ_READ, 32'h8000_0010, 32'h0, 4'h0);
    expect_rsp(1'b0, 32'hDEAD_BEEF, 1'b0);
    pulse(1'b0, MEMREQ_READ, 32'h8000_0010, 32'h0, 4'h0);
    @(negedge clk);
    check("latency_before_req", 32'(bus.request_enable), 32'h0);
    @(negedge clk);
    check("latency_req", 32'(bus.request_enable), 32'h1);
    respond_now(3, 32'hDEAD_BEEF);
    drain();
    check("m0_data_held", bus.m0_resp_data, 32'hDEAD_BEEF);

    // Simultaneous pulses, three rounds from a fresh reset
    do_reset();
    for (int r = 0; r < 3; r++) begin
      d0 = 32'hA000_0000 + 32'(r);
      d1 = 32'hB000_0000 + 32'(r);
      expect_req(1'b0, MEMREQ_READ, 32'h0000_0100 + 32'(r * 16), 32'h0, 4'h0);
      expect_req(1'b1, MEMREQ_WRITE, 32'h0000_0200 + 32'(r * 16), 32'hC0DE_0000 + 32'(r), 4'hF);
      expect_rsp(1'b0, d0, 1'b0);
      expect_rsp(1'b1, d1, 1'b0);
      drive(1'b0, MEMREQ_READ, 32'h0000_0100 + 32'(r * 16), 32'h0, 4'h0);
      drive(1'b1, MEMREQ_WRITE, 32'h0000_0200 + 32'(r * 16), 32'hC0DE_0000 + 32'(r), 4'hF);
      tick();
      mem_respond(1, d0);
      mem_respond(2, d1);
      drain();
    end

    // After a lone m0 grant, a tie exposes the arbitration policy
    expect_req(1'b0, MEMREQ_READ, 32'h0000_0300, 32'h0, 4'h0);
    expect_rsp(1'b0, 32'h0000_0300, 1'b0);
    pulse(1'b0, MEMREQ_READ, 32'h0000_0300, 32'h0, 4'h0);
    mem_respond(1, 32'h0000_0300);
    drain();
    if (RR) begin
      expect_req(1'b1, MEMREQ_READ, 32'h0000_0410, 32'h0, 4'h0);
      expect_req(1'b0, MEMREQ_READ, 32'h0000_0400, 32'h0, 4'h0);
      expect_rsp(1'b1, 32'h1111_0001, 1'b0);
      expect_rsp(1'b0, 32'h1111_0002, 1'b0);
    end else begin
      expect_req(1'b0, MEMREQ_READ, 32'h0000_0400, 32'h0, 4'h0);
      expect_req(1'b1, MEMREQ_READ, 32'h0000_0410, 32'h0, 4'h0);
      expect_rsp(1'b0, 32'h1111_0001, 1'b0);
      expect_rsp(1'b1, 32'h1111_0002, 1'b0);
    end
    drive(1'b0, MEMREQ_READ, 32'h0000_0400, 32'h0, 4'h0);
    drive(1'b1, MEMREQ_READ, 32'h0000_0410, 32'h0, 4'h0);
    tick();
    mem_respond(1, 32'h1111_0001);
    mem_respond(1, 32'h1111_0002);
    drain();

    // Second m0 pulse while pending, and one in the response cycle, are ignored
    expect_req(1'b0, MEMREQ_WRITE, 32'h0000_0040, 32'h0BAD_F00D, 4'h3);
    expect_rsp(1'b0, 32'h5555_AAAA, 1'b0);
    pulse(1'b0, MEMREQ_WRITE, 32'h0000_0040, 32'h0BAD_F00D, 4'h3);
    pulse(1'b0, MEMREQ_READ, 32'h0000_1234, 32'h0, 4'h0);
    wait_req(ok);
    if (ok) begin
      repeat (2) @(posedge clk);
      #1;
      bus.response_enable = 1'b1;
      bus.resp_data       = 32'h5555_AAAA;
      drive(1'b0, MEMREQ_READ, 32'h0000_1234, 32'h0, 4'h0);
      tick();
    end
    drain();

    // Memory never answers: m1 times out after 8 cycles, then queued m0 runs
    expect_req(1'b1, MEMREQ_READ, 32'h0000_3000, 32'h0, 4'h0);
    expect_rsp(1'b1, 32'h0, 1'b1);
    expect_req(1'b0, MEMREQ_READ, 32'h0000_4000, 32'h0, 4'h0);
    expect_rsp(1'b0, 32'h7777_0000, 1'b0);
    pulse(1'b1, MEMREQ_READ, 32'h0000_3000, 32'h0, 4'h0);
    pulse(1'b0, MEMREQ_READ, 32'h0000_4000, 32'h0, 4'h0);
    wait_req(ok);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus.m1_response_enable) begin
        n = i;
        break;
      end
    end
    check("timeout_latency", 32'(n), 32'd8);
    mem_respond(2, 32'h7777_0000);
    drain();

    // Reset during WAIT_RESP drops the transaction; a late response is ignored
    expect_req(1'b0, MEMREQ_READ, 32'h0000_5000, 32'h0, 4'h0);
    pulse(1'b0, MEMREQ_READ, 32'h0000_5000, 32'h0, 4'h0);
    wait_req(ok);
    @(posedge clk); #3;
    rstn = 1'b0;
    #1;
    check_outputs_zero("midreset");
    @(posedge clk); #1;
    bus.response_enable = 1'b1;
    bus.resp_data       = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_reset_quiet",
            32'({bus.request_enable, bus.m0_response_enable, bus.m1_response_enable}), 32'h0);
      if (i == 1) begin
        @(posedge clk); #1;
        bus.response_enable = 1'b0;
      end
    end
    expect_req(1'b1, MEMREQ_READ, 32'h0000_6000, 32'h0, 4'h0);
    expect_rsp(1'b1, 32'h6666_6666, 1'b0);
    pulse(1'b1, MEMREQ_READ, 32'h0000_6000, 32'h0, 4'h0);
    mem_respond(0, 32'h6666_6666);
    drain();

    // m1 pulse on the response edge and m0 pulse in RESPOND are both served
    expect_req(1'b0, MEMREQ_READ, 32'h0000_7000, 32'h0, 4'h0);
    expect_rsp(1'b0, 32'h1234_5678, 1'b0);
    if (RR) begin
      expect_req(1'b1, MEMREQ_READ, 32'h0000_8000, 32'h0, 4'h0);
      expect_req(1'b0, MEMREQ_READ, 32'h0000_9000, 32'h0, 4'h0);
      expect_rsp(1'b1, 32'h2222_2222, 1'b0);
      expect_rsp(1'b0, 32'h3333_3333, 1'b0);
    end else begin
      expect_req(1'b0, MEMREQ_READ, 32'h0000_9000, 32'h0, 4'h0);
      expect_req(1'b1, MEMREQ_READ, 32'h0000_8000, 32'h0, 4'h0);
      expect_rsp(1'b0, 32'h2222_2222, 1'b0);
      expect_rsp(1'b1, 32'h3333_3333, 1'b0);
    end
    pulse(1'b0, MEMREQ_READ, 32'h0000_7000, 32'h0, 4'h0);
    wait_req(ok);
    if (ok) begin
      @(posedge clk); #1;
      bus.response_enable = 1'b1;
      bus.resp_data       = 32'h1234_5678;
      drive(1'b1, MEMREQ_READ, 32'h0000_8000, 32'h0, 4'h0);
      tick();
      pulse(1'b0, MEMREQ_READ, 32'h0000_9000, 32'h0, 4'h0);
    end
    mem_respond(1, 32'h2222_2222);
    mem_respond(1, 32'h3333_3333);
    drain();

    check("final_req_queue", 32'(exp_req.size()), 32'h0);
    check("final_rsp_queues", 32'(exp_rsp0.size() + exp_rsp1.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1024, max cycles in WAIT_RESP before error response; 0 disables timeout.
REQ-002 clk  in  1  sole clock; all state changes on posedge.
REQ-003 rstn  in  1  reset, asynchronous, active-low.
REQ-004 m0_request_enable  in  1  one-cycle request pulse from requester 0 (MMU).
REQ-005 m0_req_mode  in  1  MEMREQ_READ/MEMREQ_WRITE.
REQ-006 m0_req_addr  in  32  physical address.
REQ-007 m0_req_wdata  in  32  write data.
REQ-008 m0_req_wstrb  in  4  byte strobes.
REQ-009 m0_response_enable  out  1  one-cycle response pulse.
REQ-010 m0_resp_data  out  32  read data, held until the next m0 response.
REQ-011 m0_resp_error  out  1  timeout flag, valid with m0_response_enable.
REQ-012 m1_* ports mirror REQ-004..REQ-011 for requester 1 (loader/DMA).
REQ-013 request_enable  out  1  one-cycle pulse to memory.
REQ-014 req_mode / req_addr / req_wdata / req_wstrb  out  1/32/32/4  granted request fields, stable from the request_enable cycle until the response.
REQ-015 response_enable  in  1  memory response pulse; resp_data  in  32  read data.
REQ-016 grant_id  out  1  requester currently owning the bus.

Function
REQ-017 Each requester has a pending slot; the slot captures mode/addr/wdata/wstrb and sets pending on the edge sampling its request_enable pulse.
REQ-018 A pulse arriving while that requester's pending is set is ignored; the slot is unchanged.
REQ-019 States: IDLE, WAIT_RESP, RESPOND; at most one outstanding memory transaction.
REQ-020 IDLE with any pending set: select a winner, drive its fields and request_enable=1 for exactly one cycle, set grant_id, go to WAIT_RESP; a slot becomes visible to arbitration one edge after capture (minimum pulse-to-request_enable latency 1 cycle).
REQ-021 WAIT_RESP with response_enable=1: drive mX_response_enable=1, mX_resp_data=resp_data, mX_resp_error=0 for the granted X; clear pending_X; record last_grant=X; go to RESPOND.
REQ-022 WAIT_RESP timeout: when the cycle counter reaches TIMEOUT_CYCLES without response_enable, respond with mX_resp_error=1 and mX_resp_data=32'h0, clear pending_X, go to RESPOND; the counter clears on entry to WAIT_RESP.
REQ-023 RESPOND: lasts exactly one cycle, deasserts the response pulse, returns to IDLE.
REQ-024 response_enable in IDLE or RESPOND is ignored.
REQ-025 A new pulse from X arriving in the RESPOND cycle is accepted, because pending_X is already clear.
REQ-026 The other requester's pulse arriving on the same edge as a response is captured and served from the next IDLE.

Reset
REQ-027 On rstn low, asynchronously: state=IDLE; all pending=0; counter=0; last_grant=1; every output (response pulses, resp data, errors, request_enable, req_*, grant_id) = 0.
REQ-028 Reset mid-transaction drops the in-flight request with no response; a late response_enable after reset is ignored per REQ-024.

Configuration
REQ-029 Macro MEM_ARBITER_ROUND_ROBIN_EN: when defined and both requesters are pending, the grant goes to the requester != last_grant. When undefined, requester 0 always wins (fixed priority).

Structure
REQ-030 The arbiter state enum arb_state_t and the TIMEOUT_CYCLES default belong in the shared def package, alongside the MEMREQ_READ/WRITE constants.
REQ-031 One sub-module, arb_req_slot, instantiated twice, implements the pending latch of REQ-017/018 with a clear input.

Verification
REQ-032 Single m0 read to 0x8000_0010, memory answers 3 cycles later with 0xDEAD_BEEF -> one request_enable pulse with req_addr=0x8000_0010; m0_response_enable pulse with data 0xDEAD_BEEF and error 0.
REQ-033 m0 and m1 pulse on the same edge, three rounds -> with MEM_ARBITER_ROUND_ROBIN_EN the grant order is 0,1,0,1,0,1; without it, m0 is served first in every round.
REQ-034 Memory never responds, TIMEOUT_CYCLES=8 -> m1_response_enable after 8 WAIT_RESP cycles with m1_resp_error=1 and data 0; the arbiter then serves the queued m0.
REQ-035 Second m0 pulse while m0 is pending with addr 0x1234 -> ignored; the issued req_addr is the original address.
REQ-036 rstn low during WAIT_RESP, then response_enable asserted -> no response pulses, all outputs 0, state IDLE.
